// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, LSB-first, one bit per clock
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_a_q;
    logic [WIDTH-1:0] shreg_b_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    count_q;

    logic             s_bit;
    logic             carry_d;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] result_d;

    // One-bit full-add slice on the current LSBs plus the carry flip-flop.
    assign s_bit    = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
    assign carry_d  = (shreg_a_q[0] & shreg_b_q[0]) |
                      (shreg_a_q[0] & carry_q) |
                      (shreg_b_q[0] & carry_q);
    assign last_bit = (count_q == CW'(WIDTH - 1));
    assign accept   = in_ready & in_valid;
    assign result_d = {s_bit, result_q[WIDTH-1:1]};

    assign sum  = sum_q;
    assign cout = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded from the state register only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand load, serial shift, and capture of the finished word into sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_a_q <= '0;
            shreg_b_q <= '0;
            result_q  <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            count_q   <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            shreg_a_q <= a;
            shreg_b_q <= sub ? ~b : b;
            carry_q   <= sub;
            count_q   <= '0;
            result_q  <= '0;
        end else if (state_q == SHIFT) begin
            shreg_a_q <= {1'b0, shreg_a_q[WIDTH-1:1]};
            shreg_b_q <= {1'b0, shreg_b_q[WIDTH-1:1]};
            carry_q   <= carry_d;
            result_q  <= result_d;
            count_q   <= count_q + CW'(1);
            // sum/cout only change here so they hold the previous result meanwhile.
            if (last_bit) begin
                sum_q  <= result_d;
                cout_q <= carry_d;
            end
        end
    end

endmodule
